// File: rtl/dm_pkg.sv
// Shared debug-module SBA types: beat-splitter FSM states and sberror codes.
package dm_pkg;

    typedef enum logic [2:0] {
        Idle  = 3'd0,
        Issue = 3'd1,
        Wait  = 3'd2,
        Done  = 3'd3,
        Flush = 3'd4
    } sba_split_state_e;

    localparam logic [2:0] SbErrNone    = 3'd0;
    localparam logic [2:0] SbErrBadAddr = 3'd2;
    localparam logic [2:0] SbErrAlign   = 3'd3;
    localparam logic [2:0] SbErrSize    = 3'd4;
    localparam logic [2:0] SbErrOther   = 3'd7;

endpackage

// File: rtl/dm_sba_lane_align.sv
// Combinational lane steering for one SBA beat: byte enables,
// write-data lane placement and sub-bus read-data extraction.
module dm_sba_lane_align
    import dm_pkg::*;
#(
    parameter int unsigned BusWidth = 32,
    parameter int unsigned DW       = 128,
    parameter int unsigned CW       = 3,
    parameter int unsigned OW       = $clog2(BusWidth / 8)
) (
    input  logic [2:0]            sbaccess_i,
    input  logic [OW-1:0]         offset_i,
    input  logic [CW-1:0]         beat_i,
    input  logic [DW-1:0]         wdata_i,
    input  logic [BusWidth-1:0]   rdata_i,
    output logic                  sub_o,
    output logic [BusWidth/8-1:0] be_o,
    output logic [BusWidth-1:0]   wdata_o,
    output logic [BusWidth-1:0]   rdata_o
);

    localparam int unsigned NBytes = BusWidth / 8;
    localparam int unsigned NSlice = (DW > BusWidth) ? DW / BusWidth : 1;
    localparam logic [2:0]  BusLog = 3'(OW);

    logic [BusWidth-1:0] wsel;
    logic [BusWidth-1:0] wlow;
    logic [BusWidth-1:0] rsh;
    int unsigned         nbytes;
    int unsigned         off;

    always_comb begin
        sub_o   = sbaccess_i < BusLog;
        nbytes  = 32'd1 << sbaccess_i;
        off     = 32'(offset_i);
        rsh     = rdata_i >> (off * 8);
        wsel    = '0;
        wlow    = '0;
        be_o    = '0;
        rdata_o = '0;
        for (int unsigned k = 0; k < NSlice; k++) begin
            if (beat_i == CW'(k)) wsel = wdata_i[k*BusWidth +: BusWidth];
        end
        // Sub-bus data is masked to the access size so idle lanes stay quiet.
        for (int unsigned i = 0; i < NBytes; i++) begin
            if (!sub_o || (i >= off && i < off + nbytes)) be_o[i] = 1'b1;
            if (!sub_o || i < nbytes) begin
                wlow[i*8 +: 8]    = wdata_i[i*8 +: 8];
                rdata_o[i*8 +: 8] = rsh[i*8 +: 8];
            end
        end
        wdata_o = sub_o ? (wlow << (off * 8)) : wsel;
    end

endmodule

// File: rtl/dm_sba_beat_splitter.sv
// SBA engine: splits one access into aligned bus beats and reassembles reads.
// Define DM_SBA_ALIGN_CHECK_EN to reject misaligned addresses with sberror 3.
module dm_sba_beat_splitter
    import dm_pkg::*;
#(
    parameter int unsigned BusWidth       = 32,
    parameter int unsigned MaxAccess      = 4,
    parameter bit          ReadByteEnable = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      dmactive_i,
    input  logic                      req_i,
    output logic                      ready_o,
    input  logic                      we_i,
    input  logic [BusWidth-1:0]       addr_i,
    input  logic [2:0]                sbaccess_i,
    input  logic [(8<<MaxAccess)-1:0] wdata_i,
    output logic                      done_o,
    output logic [(8<<MaxAccess)-1:0] rdata_o,
    output logic [2:0]                error_o,
    output logic                      master_req_o,
    output logic [BusWidth-1:0]       master_add_o,
    output logic                      master_we_o,
    output logic [BusWidth-1:0]       master_wdata_o,
    output logic [BusWidth/8-1:0]     master_be_o,
    input  logic                      master_gnt_i,
    input  logic                      master_r_valid_i,
    input  logic                      master_r_err_i,
    input  logic                      master_r_other_err_i,
    input  logic [BusWidth-1:0]       master_r_rdata_i
);

    localparam int unsigned DW      = 8 << MaxAccess;
    localparam int unsigned NBytes  = BusWidth / 8;
    localparam int unsigned OW      = $clog2(NBytes);
    localparam int unsigned NBMax   = (DW > BusWidth) ? DW / BusWidth : 1;
    localparam int unsigned CW      = $clog2(NBMax) + 1;
    localparam logic [2:0]  MaxSize = 3'(MaxAccess);
    localparam logic [2:0]  BusLog  = 3'(OW);

    sba_split_state_e    state_q, state_d;
    logic                we_q, we_d;
    logic [BusWidth-1:0] addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic [CW-1:0]       beat_q, beat_d;
    logic [CW-1:0]       last_q, last_d;
    logic [2:0]          err_q, err_d;

    logic [BusWidth-1:0] size_mask;
    logic [BusWidth-1:0] beat_addr;
    logic                issue;
    logic                lane_sub;
    logic [NBytes-1:0]   lane_be;
    logic [BusWidth-1:0] lane_wdata;
    logic [BusWidth-1:0] lane_rdata;

    dm_sba_lane_align #(
        .BusWidth(BusWidth),
        .DW      (DW),
        .CW      (CW),
        .OW      (OW)
    ) u_lane (
        .sbaccess_i(size_q),
        .offset_i  (addr_q[OW-1:0]),
        .beat_i    (beat_q),
        .wdata_i   (wdata_q),
        .rdata_i   (master_r_rdata_i),
        .sub_o     (lane_sub),
        .be_o      (lane_be),
        .wdata_o   (lane_wdata),
        .rdata_o   (lane_rdata)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        beat_d    = beat_q;
        last_d    = last_q;
        err_d     = err_q;
        size_mask = (BusWidth'(1) << sbaccess_i) - BusWidth'(1);

        unique case (state_q)
            Idle: begin
                if (req_i && dmactive_i) begin
                    we_d    = we_i;
                    size_d  = sbaccess_i;
                    wdata_d = wdata_i;
                    beat_d  = '0;
                    err_d   = SbErrNone;
                    state_d = Issue;
                    last_d  = (sbaccess_i > BusLog) ?
                              CW'((32'd1 << (sbaccess_i - BusLog)) - 32'd1) : '0;
                    if (!we_i) rdata_d = '0;
`ifdef DM_SBA_ALIGN_CHECK_EN
                    addr_d = addr_i;
                    if (sbaccess_i > MaxSize) begin
                        err_d   = SbErrSize;
                        state_d = Done;
                    end else if ((addr_i & size_mask) != '0) begin
                        err_d   = SbErrAlign;
                        state_d = Done;
                    end
`else
                    addr_d = addr_i & ~size_mask;
                    if (sbaccess_i > MaxSize) begin
                        err_d   = SbErrSize;
                        state_d = Done;
                    end
`endif
                end
            end
            Issue: begin
                if (!dmactive_i) state_d = Idle;
                else if (master_gnt_i) state_d = Wait;
            end
            Wait: begin
                if (!dmactive_i) begin
                    state_d = master_r_valid_i ? Idle : Flush;
                end else if (master_r_valid_i) begin
                    if (master_r_err_i) begin
                        err_d   = SbErrBadAddr;
                        state_d = Done;
                    end else if (master_r_other_err_i) begin
                        err_d   = SbErrOther;
                        state_d = Done;
                    end else begin
                        if (!we_q) begin
                            if (lane_sub) begin
                                rdata_d = DW'(lane_rdata);
                            end else begin
                                for (int unsigned k = 0; k < NBMax; k++) begin
                                    if (beat_q == CW'(k))
                                        rdata_d[k*BusWidth +: BusWidth] = master_r_rdata_i;
                                end
                            end
                        end
                        if (beat_q == last_q) begin
                            state_d = Done;
                        end else begin
                            beat_d  = beat_q + CW'(1);
                            state_d = Issue;
                        end
                    end
                end
            end
            Done: state_d = Idle;
            Flush: begin
                if (master_r_valid_i) state_d = Idle;
            end
            default: state_d = Idle;
        endcase
    end

    // Beat k sits k bus words above the bus-aligned base; wraps naturally.
    assign beat_addr = (addr_q & ~BusWidth'(NBytes - 1)) + (BusWidth'(beat_q) << OW);
    assign issue     = (state_q == Issue) && dmactive_i;

    assign ready_o        = state_q == Idle;
    assign done_o         = state_q == Done;
    assign rdata_o        = rdata_q;
    assign error_o        = err_q;
    assign master_req_o   = issue;
    assign master_add_o   = issue ? beat_addr : '0;
    assign master_we_o    = issue && we_q;
    assign master_wdata_o = (issue && we_q) ? lane_wdata : '0;
    assign master_be_o    = !issue ? '0 :
                            (we_q || ReadByteEnable) ? lane_be : '1;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= Idle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            beat_q  <= '0;
            last_q  <= '0;
            err_q   <= SbErrNone;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dm_sba_beat_splitter.sv
// Scoreboard bench for dm_sba_beat_splitter (BusWidth=32, MaxAccess=4).
// Honours DM_SBA_ALIGN_CHECK_EN in its reference model.
module tb_dm_sba_beat_splitter;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         dmactive_i = 1'b1;
    logic         req_i = 1'b0;
    logic         ready_o;
    logic         we_i = 1'b0;
    logic [31:0]  addr_i = '0;
    logic [2:0]   sbaccess_i = '0;
    logic [127:0] wdata_i = '0;
    logic         done_o;
    logic [127:0] rdata_o;
    logic [2:0]   error_o;
    logic         master_req_o;
    logic [31:0]  master_add_o;
    logic         master_we_o;
    logic [31:0]  master_wdata_o;
    logic [3:0]   master_be_o;
    logic         master_gnt_i = 1'b0;
    logic         master_r_valid_i = 1'b0;
    logic         master_r_err_i = 1'b0;
    logic         master_r_other_err_i = 1'b0;
    logic [31:0]  master_r_rdata_i = '0;

    dm_sba_beat_splitter #(
        .BusWidth      (32),
        .MaxAccess     (4),
        .ReadByteEnable(1'b1)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .dmactive_i          (dmactive_i),
        .req_i               (req_i),
        .ready_o             (ready_o),
        .we_i                (we_i),
        .addr_i              (addr_i),
        .sbaccess_i          (sbaccess_i),
        .wdata_i             (wdata_i),
        .done_o              (done_o),
        .rdata_o             (rdata_o),
        .error_o             (error_o),
        .master_req_o        (master_req_o),
        .master_add_o        (master_add_o),
        .master_we_o         (master_we_o),
        .master_wdata_o      (master_wdata_o),
        .master_be_o         (master_be_o),
        .master_gnt_i        (master_gnt_i),
        .master_r_valid_i    (master_r_valid_i),
        .master_r_err_i      (master_r_err_i),
        .master_r_other_err_i(master_r_other_err_i),
        .master_r_rdata_i    (master_r_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] add;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        oerr;
        int          delay;
    } resp_t;

    typedef struct {
        logic [2:0]   err;
        logic         chk;
        logic [127:0] rdata;
    } done_t;

    beat_t exp_beat_q[$];
    resp_t resp_q[$];
    done_t exp_done_q[$];

    int errors = 0;
    int checks = 0;
    int gnt_cnt = 0;
    logic [127:0] last_rd = '0;
    bit last_ok = 1'b1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus slave: random grant, then a response after the planned delay.
    initial begin : bus
        resp_t cur;
        beat_t e;
        int cnt;
        bit pend;
        pend = 1'b0;
        cnt = 0;
        cur = '{rdata: 32'h0, err: 1'b0, oerr: 1'b0, delay: 0};
        forever begin
            @(negedge clk_i);
            #1;
            master_gnt_i = 1'b0;
            master_r_valid_i = 1'b0;
            master_r_err_i = 1'b0;
            master_r_other_err_i = 1'b0;
            master_r_rdata_i = '0;
            if (!rst_ni) begin
                pend = 1'b0;
            end else if (pend) begin
                if (cnt == 0) begin
                    master_r_valid_i = 1'b1;
                    master_r_err_i = cur.err;
                    master_r_other_err_i = cur.oerr;
                    master_r_rdata_i = cur.rdata;
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (master_req_o && $urandom_range(0, 2) != 0) begin
                master_gnt_i = 1'b1;
                gnt_cnt++;
                if (exp_beat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat: unexpected beat at %h", master_add_o);
                end else begin
                    e = exp_beat_q.pop_front();
                    check("beat_add", master_add_o, e.add);
                    check("beat_be", master_be_o, e.be);
                    check("beat_we", master_we_o, e.we);
                    if (e.we) check("beat_wdata", master_wdata_o, e.wdata);
                end
                if (resp_q.size() != 0) cur = resp_q.pop_front();
                else cur = '{rdata: 32'h0, err: 1'b0, oerr: 1'b0, delay: 0};
                cnt = cur.delay;
                pend = 1'b1;
            end
        end
    end

    initial begin : done_mon
        done_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (rst_ni && done_o) begin
                if (exp_done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done: unexpected done_o error=%0d", error_o);
                end else begin
                    e = exp_done_q.pop_front();
                    check("done_err", error_o, e.err);
                    if (e.chk) check("done_rdata", rdata_o, e.rdata);
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clk_i);
        #3;
        while (!ready_o && n < 300) begin
            @(negedge clk_i);
            #3;
            n++;
        end
        checks++;
        if (!ready_o) begin
            errors++;
            $display("FAIL %s: ready_o=0 after timeout, expected 1", name);
        end
    endtask

    task automatic drive_req(input bit we, input logic [31:0] addr,
                             input int s, input logic [127:0] wd);
        wait_ready("pre_req");
        req_i = 1'b1;
        we_i = we;
        addr_i = addr;
        sbaccess_i = 3'(s);
        wdata_i = wd;
        @(negedge clk_i);
        req_i = 1'b0;
    endtask

    // Reference model: derive beats, bus responses and the final result.
    task automatic run_txn(input bit we, input logic [31:0] addr, input int s,
                           input logic [127:0] wd, input int err_beat, input int kind,
                           input logic [31:0] r0, input int dly_max);
        int bytes, nb, off;
        logic [31:0] a;
        logic [63:0] tmp;
        logic [127:0] wsh, rd;
        logic [2:0] err;
        beat_t b;
        resp_t r;
        done_t d;
        err = 3'd0;
        rd = '0;
        if (s > 4) begin
            err = 3'd4;
        end else begin
            bytes = 1 << s;
`ifdef DM_SBA_ALIGN_CHECK_EN
            if (addr % 32'(bytes) != 0) err = 3'd3;
`endif
            if (err == 3'd0) begin
                a = addr - (addr % 32'(bytes));
                nb = (bytes < 4) ? 1 : bytes / 4;
                off = (bytes < 4) ? int'(a % 4) : 0;
                for (int k = 0; k < nb; k++) begin
                    b.add = (a & ~32'd3) + 32'(4 * k);
                    b.we = we;
                    if (bytes < 4) begin
                        b.be = 4'(((1 << bytes) - 1) << off);
                        tmp = (64'(wd[31:0]) & ((64'd1 << (8 * bytes)) - 1)) << (8 * off);
                        b.wdata = tmp[31:0];
                    end else begin
                        b.be = 4'hF;
                        wsh = wd >> (32 * k);
                        b.wdata = wsh[31:0];
                    end
                    r.rdata = (k == 0) ? r0 : $urandom;
                    r.delay = $urandom_range(0, dly_max);
                    r.err = (k == err_beat) && kind != 1;
                    r.oerr = (k == err_beat) && kind != 0;
                    exp_beat_q.push_back(b);
                    resp_q.push_back(r);
                    if (k == err_beat) begin
                        err = (kind == 1) ? 3'd7 : 3'd2;
                        break;
                    end
                    if (!we) begin
                        if (bytes < 4) begin
                            tmp = (64'(r.rdata) >> (8 * off)) & ((64'd1 << (8 * bytes)) - 1);
                            rd = 128'(tmp);
                        end else begin
                            rd = rd | (128'(r.rdata) << (32 * k));
                        end
                    end
                end
            end
        end
        d.err = err;
        if (!we) begin
            d.chk = (err == 3'd0);
            d.rdata = rd;
            last_ok = (err == 3'd0);
            last_rd = rd;
        end else begin
            d.chk = last_ok;
            d.rdata = last_rd;
        end
        exp_done_q.push_back(d);
        drive_req(we, addr, s, wd);
        wait_ready("txn_done");
    endtask

    task automatic run_abort();
        beat_t b;
        resp_t r;
        int g, n;
        b = '{add: 32'h5000, we: 1'b0, be: 4'hF, wdata: 32'h0};
        r = '{rdata: 32'hDEADBEEF, err: 1'b0, oerr: 1'b0, delay: 6};
        exp_beat_q.push_back(b);
        resp_q.push_back(r);
        last_ok = 1'b0;
        drive_req(1'b0, 32'h5000, 2, '0);
        g = gnt_cnt;
        n = 0;
        while (gnt_cnt == g && n < 100) begin
            @(negedge clk_i);
            #3;
            n++;
        end
        check("abort_gnt", 1'(gnt_cnt != g), 1'b1);
        @(negedge clk_i);
        dmactive_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        #3;
        check("flush_ready", ready_o, 1'b0);
        check("flush_req", master_req_o, 1'b0);
        wait_ready("flush_exit");
        dmactive_i = 1'b1;
    endtask

    initial begin : stim
        logic [127:0] wd;
        repeat (3) @(negedge clk_i);
        #2;
        check("rst_ready", ready_o, 1'b1);
        check("rst_done", done_o, 1'b0);
        check("rst_req", master_req_o, 1'b0);
        check("rst_err", error_o, 3'd0);
        check("rst_rdata", rdata_o, 128'd0);
        check("rst_be", master_be_o, 4'd0);
        rst_ni = 1'b1;

        run_txn(1'b1, 32'h1000, 4, 128'h33333333_22222222_11111111_00000000, -1, 0, 32'h0, 2);
        run_txn(1'b0, 32'h2003, 0, '0, -1, 0, 32'hAB000000, 2);
        check("byte_read", rdata_o, 128'hAB);
        run_txn(1'b1, 32'h0010, 5, 128'h1234, -1, 0, 32'h0, 2);
        run_txn(1'b0, 32'h4000, 3, '0, 0, 0, 32'h0, 2);
        run_txn(1'b1, 32'h3001, 1, 128'hBEEF, -1, 0, 32'h0, 2);
        run_abort();
        run_txn(1'b0, 32'h6000, 2, '0, -1, 0, 32'hCAFEF00D, 1);
        check("post_abort_rdata", rdata_o, 128'hCAFEF00D);

        dmactive_i = 1'b0;
        req_i = 1'b1;
        repeat (3) @(negedge clk_i);
        req_i = 1'b0;
        #3;
        check("inactive_idle", ready_o, 1'b1);
        dmactive_i = 1'b1;

        run_txn(1'b0, 32'hFFFF_FFF8, 4, '0, -1, 0, $urandom, 1);
        run_txn(1'b0, 32'h7000, 4, '0, 2, 2, $urandom, 1);

        for (int i = 0; i < 150; i++) begin
            wd = {$urandom, $urandom, $urandom, $urandom};
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 5), wd,
                    ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1,
                    $urandom_range(0, 2), $urandom, 3);
        end

        repeat (5) @(negedge clk_i);
        check("beats_left", 32'(exp_beat_q.size()), 32'd0);
        check("dones_left", 32'(exp_done_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
